// File: rtl/axi_lite_reg_pkg.sv
// Shared constants and types for the AXI4-Lite register bank.
//   RESP_*   : AXI response codes
//   OFS_*    : fixed register offsets (decode uses addr[11:0])
//   *_BASE   : start of the RW / RO register arrays
//   w_state_t, r_state_t : write / read channel FSM states
package axi_lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [11:0] OFS_VERSION    = 12'h000;
    localparam logic [11:0] OFS_IRQ_STATUS = 12'h004;
    localparam logic [11:0] OFS_IRQ_ENABLE = 12'h008;
    localparam logic [11:0] RW_BASE        = 12'h100;
    localparam logic [11:0] RO_BASE        = 12'h200;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Expand 4 byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
        return mask;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels).
//   slave  : register-bank side
//   master : bus-initiator side
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/reg_irq_ctrl.sv
// Interrupt status (W1C) / enable (RW) registers with a registered level irq.
//   clk, rst    : clock, synchronous active-high reset
//   irq_events  : level events, set status bits every cycle they are high
//   en_we       : write enable for IRQ_ENABLE (byte-masked by wmask)
//   st_clr      : W1C write to IRQ_STATUS (clear bits = wdata & wmask)
//   status, enable : current register contents
//   irq         : registered OR of status & enable
module reg_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_events,
    input  logic               en_we,
    input  logic               st_clr,
    input  logic [NUM_IRQ-1:0] wdata,
    input  logic [NUM_IRQ-1:0] wmask,
    output logic [NUM_IRQ-1:0] status,
    output logic [NUM_IRQ-1:0] enable,
    output logic               irq
);
    logic [NUM_IRQ-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        if (st_clr) clr_mask = wdata & wmask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            enable <= '0;
            irq    <= 1'b0;
        end else begin
            // Event set is OR-ed in after the clear, so a set wins.
            status <= (status & ~clr_mask) | irq_events;
            if (en_we) enable <= (enable & ~wmask) | (wdata & wmask);
            irq <= |(status & enable);
        end
    end
endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: VERSION, IRQ status/enable, NUM_RW RW registers
// and NUM_RO RO registers. Write and read channels run independent FSMs.
//   clk, rst     : clock, synchronous active-high reset
//   axi          : AXI4-Lite slave port
//   rw_regs      : RW register contents, reg i at [32i+31:32i]
//   rw_wr_pulse  : one-cycle strobe per RW register on an OKAY write
//   ro_regs      : RO register values, sampled on AR handshake
//   irq_events   : interrupt event levels
//   irq          : registered interrupt output
module axi_lite_reg_bank
    import axi_lite_reg_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_RW     = 8,
    parameter int                   NUM_RO     = 8,
    parameter int                   NUM_IRQ    = 8,
    parameter logic [31:0]          VERSION    = 32'h0002_0000,
    parameter logic [NUM_RW*32-1:0] RW_RESET   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_lite_if.slave           axi,
    output logic [NUM_RW*32-1:0] rw_regs,
    output logic [NUM_RW-1:0]    rw_wr_pulse,
    input  logic [NUM_RO*32-1:0] ro_regs,
    input  logic [NUM_IRQ-1:0]   irq_events,
    output logic                 irq
);
    localparam int STRB_W = DATA_WIDTH / 8;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  aw_held, w_held;
    logic [11:0]           aw_ofs;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_hs, w_hs, ar_hs, exec;

    logic [NUM_RW-1:0][31:0] rw_q;
    logic [NUM_IRQ-1:0]      irq_status, irq_enable;

    logic                  wr_ok, wr_rw_hit, wr_en_we, wr_st_we;
    logic [31:0]           wr_mask;
    logic [11:0]           ar_ofs;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    // Address bits above the 4 KiB decode window are ignored.
    logic unused_addr;
    assign unused_addr = ^{axi.awaddr[ADDR_WIDTH-1:12], axi.araddr[ADDR_WIDTH-1:12]};

    // Readies are forced low during reset so nothing is accepted then.
    assign axi.awready = !rst && !aw_held;
    assign axi.wready  = !rst && !w_held;
    assign axi.arready = !rst && (r_state == R_IDLE);
    assign axi.bvalid  = (w_state == W_RESP);
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (r_state == R_DATA);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign exec  = (w_state == W_EXEC);

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (axi.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_ofs  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_ofs  <= axi.awaddr[11:0];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
            end
            if (exec) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_state == W_RESP && axi.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Write decode from the held address; only acted on in W_EXEC.
    always_comb begin
        wr_rw_hit = 1'b0;
        wr_en_we  = 1'b0;
        wr_st_we  = 1'b0;
        if (aw_ofs[1:0] == 2'b00) begin
            if (aw_ofs == OFS_IRQ_STATUS)      wr_st_we = 1'b1;
            else if (aw_ofs == OFS_IRQ_ENABLE) wr_en_we = 1'b1;
            else if (aw_ofs[11:8] == RW_BASE[11:8])
                for (int i = 0; i < NUM_RW; i++)
                    if (aw_ofs[7:2] == 6'(i)) wr_rw_hit = 1'b1;
        end
        wr_ok = wr_rw_hit || wr_en_we || wr_st_we;
    end

    assign wr_mask = strb_to_mask(wstrb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q        <= RW_RESET;
            rw_wr_pulse <= '0;
        end else begin
            rw_wr_pulse <= '0;
            if (exec && wr_rw_hit) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (aw_ofs[7:2] == 6'(i)) begin
                        rw_wr_pulse[i] <= 1'b1;
                        rw_q[i]        <= (rw_q[i] & ~wr_mask) | (wdata_q & wr_mask);
                    end
                end
            end
        end
    end

    assign rw_regs = rw_q;

    reg_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
        .clk        (clk),
        .rst        (rst),
        .irq_events (irq_events),
        .en_we      (exec && wr_en_we),
        .st_clr     (exec && wr_st_we),
        .wdata      (wdata_q[NUM_IRQ-1:0]),
        .wmask      (wr_mask[NUM_IRQ-1:0]),
        .status     (irq_status),
        .enable     (irq_enable),
        .irq        (irq)
    );

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (axi.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_ofs = axi.araddr[11:0];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (ar_ofs[1:0] == 2'b00) begin
            if (ar_ofs == OFS_VERSION) begin
                rd_data = VERSION;
                rd_resp = RESP_OKAY;
            end else if (ar_ofs == OFS_IRQ_STATUS) begin
                rd_data = DATA_WIDTH'(irq_status);
                rd_resp = RESP_OKAY;
            end else if (ar_ofs == OFS_IRQ_ENABLE) begin
                rd_data = DATA_WIDTH'(irq_enable);
                rd_resp = RESP_OKAY;
            end else if (ar_ofs[11:8] == RW_BASE[11:8]) begin
                for (int i = 0; i < NUM_RW; i++)
                    if (ar_ofs[7:2] == 6'(i)) begin
                        rd_data = rw_q[i];
                        rd_resp = RESP_OKAY;
                    end
            end else if (ar_ofs[11:8] == RO_BASE[11:8]) begin
                for (int i = 0; i < NUM_RO; i++)
                    if (ar_ofs[7:2] == 6'(i)) begin
                        rd_data = ro_regs[32*i +: 32];
                        rd_resp = RESP_OKAY;
                    end
            end
        end
    end

    // rdata captures pre-edge register state, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
module tb_axi_lite_reg_bank;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [8*32-1:0] rw_regs;
    logic [7:0]      rw_wr_pulse;
    logic [8*32-1:0] ro_regs;
    logic [7:0]      irq_events;
    logic            irq;

    int checks = 0;
    int errors = 0;

    axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi();

    axi_lite_reg_bank dut (
        .clk         (clk),
        .rst         (rst),
        .axi         (axi),
        .rw_regs     (rw_regs),
        .rw_wr_pulse (rw_wr_pulse),
        .ro_regs     (ro_regs),
        .irq_events  (irq_events),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the B handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0, got = 0, aw_hs, w_hs;
        int n = 0;
        resp = 2'bxx;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  axi.wvalid = 1'b0; end
            n++;
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (axi.bvalid) begin got = 1; resp = axi.bresp; end
            @(posedge clk); #1;
            n++;
        end
        axi.bready = 1'b0;
        ok = aw_done && w_done && got;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
        bit ar_done = 0, got = 0, ar_hs;
        int n = 0;
        d = 'x; resp = 2'bxx;
        axi.araddr = a; axi.arvalid = 1'b1;
        while (!ar_done && n < 20) begin
            @(negedge clk);
            ar_hs = axi.arready;
            @(posedge clk); #1;
            if (ar_hs) begin ar_done = 1; axi.arvalid = 1'b0; end
            n++;
        end
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (axi.rvalid) begin got = 1; d = axi.rdata; resp = axi.rresp; end
            @(posedge clk); #1;
            n++;
        end
        axi.rready = 1'b0;
        ok = ar_done && got;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        bit          ok;
        int          n;

        vecs[0]  = '{0, 32'h000, 32'h0,         4'h0, 32'h0002_0000, OKAY};
        vecs[1]  = '{0, 32'h004, 32'h0,         4'h0, 32'h0,         OKAY};
        vecs[2]  = '{0, 32'h008, 32'h0,         4'h0, 32'h0,         OKAY};
        vecs[3]  = '{1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0,         OKAY};
        vecs[4]  = '{0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, OKAY};
        vecs[5]  = '{1, 32'h11C, 32'h1234_5678, 4'hC, 32'h0,         OKAY};
        vecs[6]  = '{0, 32'h11C, 32'h0,         4'h0, 32'h1234_0000, OKAY};
        vecs[7]  = '{1, 32'h104, 32'hFFFF_FFFF, 4'h0, 32'h0,         OKAY};
        vecs[8]  = '{0, 32'h104, 32'h0,         4'h0, 32'h0,         OKAY};
        vecs[9]  = '{1, 32'h200, 32'hFFFF_FFFF, 4'hF, 32'h0,         SLVERR};
        vecs[10] = '{0, 32'h200, 32'h0,         4'h0, 32'hC0DE_0000, OKAY};
        vecs[11] = '{0, 32'h21C, 32'h0,         4'h0, 32'hC0DE_0007, OKAY};
        vecs[12] = '{1, 32'h000, 32'hFFFF_FFFF, 4'hF, 32'h0,         SLVERR};
        vecs[13] = '{0, 32'h000, 32'h0,         4'h0, 32'h0002_0000, OKAY};
        vecs[14] = '{0, 32'h006, 32'h0,         4'h0, 32'h0,         SLVERR};
        vecs[15] = '{0, 32'h300, 32'h0,         4'h0, 32'h0,         SLVERR};
        vecs[16] = '{0, 32'h120, 32'h0,         4'h0, 32'h0,         SLVERR};
        vecs[17] = '{1, 32'h102, 32'h1111_1111, 4'hF, 32'h0,         SLVERR};
        vecs[18] = '{0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, OKAY};
        vecs[19] = '{1, 32'h008, 32'hFFFF_FF0F, 4'h1, 32'h0,         OKAY};
        vecs[20] = '{0, 32'h008, 32'h0,         4'h0, 32'h0000_000F, OKAY};
        vecs[21] = '{1, 32'h008, 32'h0,         4'hF, 32'h0,         OKAY};
        vecs[22] = '{0, 32'h224, 32'h0,         4'h0, 32'h0,         SLVERR};

        for (int i = 0; i < 8; i++) ro_regs[32*i +: 32] = 32'hC0DE_0000 + i;
        irq_events = '0;
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0;  axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_bresp", axi.bresp, OKAY);
        chk("rst_rresp", axi.rresp, OKAY);
        chk("rst_rw_regs_lo", rw_regs[31:0], 0);
        chk("rst_pulse", rw_wr_pulse, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);

        // ---- VERSION read latency and R backpressure ----
        @(posedge clk); #1;
        axi.araddr = 32'h000; axi.arvalid = 1'b1;
        @(negedge clk);
        chk("ver_arready", axi.arready, 1);
        chk("ver_rvalid_pre", axi.rvalid, 0);
        @(posedge clk); #1 axi.arvalid = 1'b0;
        @(negedge clk);
        chk("ver_rvalid", axi.rvalid, 1);
        chk("ver_rdata", axi.rdata, 32'h0002_0000);
        chk("ver_rresp", axi.rresp, OKAY);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ver_rvalid_hold", axi.rvalid, 1);
        chk("ver_rdata_hold", axi.rdata, 32'h0002_0000);
        chk("ver_arready_busy", axi.arready, 0);
        axi.rready = 1'b1;
        @(posedge clk); #1 axi.rready = 1'b0;
        @(negedge clk);
        chk("ver_rvalid_done", axi.rvalid, 0);

        // ---- byte strobes, W two cycles ahead of AW ----
        @(posedge clk); #1;
        axi.wdata = 32'hA5A5_A5A5; axi.wstrb = 4'b0101; axi.wvalid = 1'b1;
        @(negedge clk);
        chk("bs_wready", axi.wready, 1);
        @(posedge clk); #1 axi.wvalid = 1'b0;
        @(negedge clk);
        chk("bs_wready_held", axi.wready, 0);
        chk("bs_awready_idle", axi.awready, 1);
        chk("bs_bvalid_early", axi.bvalid, 0);
        @(posedge clk); #1;
        axi.awaddr = 32'h108; axi.awvalid = 1'b1;
        @(negedge clk);
        chk("bs_awready", axi.awready, 1);
        @(posedge clk); #1 axi.awvalid = 1'b0;
        @(negedge clk);
        chk("bs_exec_bvalid", axi.bvalid, 0);
        chk("bs_exec_pulse", rw_wr_pulse, 8'h00);
        @(posedge clk); #1 axi.bready = 1'b1;
        @(negedge clk);
        chk("bs_bvalid", axi.bvalid, 1);
        chk("bs_bresp", axi.bresp, OKAY);
        chk("bs_pulse", rw_wr_pulse, 8'h04);
        chk("bs_rw2", rw_regs[95:64], 32'h00A5_00A5);
        @(posedge clk); #1 axi.bready = 1'b0;
        @(negedge clk);
        chk("bs_pulse_end", rw_wr_pulse, 8'h00);
        chk("bs_bvalid_end", axi.bvalid, 0);
        @(posedge clk); #1;
        do_read(32'h108, rd, rsp, ok);
        chk("bs_read_ok", ok, 1);
        chk("bs_read", rd, 32'h00A5_00A5);

        // ---- table-driven vectors ----
        for (int i = 0; i < 23; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp, ok);
                chk($sformatf("vec%0d_done", i), ok, 1);
                chk($sformatf("vec%0d_bresp", i), rsp, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, rd, rsp, ok);
                chk($sformatf("vec%0d_done", i), ok, 1);
                chk($sformatf("vec%0d_rresp", i), rsp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
            end
        end
        chk("rw0_port", rw_regs[31:0], 32'hDEAD_BEEF);
        chk("rw7_port", rw_regs[255:224], 32'h1234_0000);

        // ---- interrupts ----
        do_write(32'h008, 32'h1, 4'hF, rsp, ok);
        chk("irq_en_wr", rsp, OKAY);
        irq_events = 8'h01;
        @(posedge clk); #1 irq_events = 8'h00;
        @(negedge clk);
        chk("irq_lag", irq, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("irq_set", irq, 1);
        @(posedge clk); #1;
        do_read(32'h004, rd, rsp, ok);
        chk("irq_status_set", rd, 32'h1);
        irq_events = 8'h01;
        do_write(32'h004, 32'h1, 4'hF, rsp, ok);
        irq_events = 8'h00;
        chk("irq_w1c_race_resp", rsp, OKAY);
        do_read(32'h004, rd, rsp, ok);
        chk("irq_set_wins", rd, 32'h1);
        chk("irq_still_high", irq, 1);
        do_write(32'h004, 32'h1, 4'hF, rsp, ok);
        @(negedge clk);
        chk("irq_cleared", irq, 0);
        @(posedge clk); #1;
        do_read(32'h004, rd, rsp, ok);
        chk("irq_status_clr", rd, 32'h0);

        // ---- same-cycle read and write of RW[0] ----
        axi.awaddr = 32'h100; axi.wdata = 32'h1234; axi.wstrb = 4'hF;
        axi.araddr = 32'h100;
        axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
        @(negedge clk);
        chk("cc_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
        axi.rready = 1; axi.bready = 1;
        @(negedge clk);
        chk("cc_rvalid", axi.rvalid, 1);
        chk("cc_old_value", axi.rdata, 32'hDEAD_BEEF);
        n = 0;
        while (!axi.bvalid && n < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("cc_bvalid", axi.bvalid, 1);
        @(posedge clk); #1;
        axi.rready = 0; axi.bready = 0;
        do_read(32'h100, rd, rsp, ok);
        chk("cc_new_value", rd, 32'h1234);

        // ---- B backpressure ----
        axi.awaddr = 32'h104; axi.wdata = 32'h55; axi.wstrb = 4'hF;
        axi.awvalid = 1; axi.wvalid = 1;
        @(negedge clk);
        chk("bp_ready", {axi.awready, axi.wready}, 2'b11);
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
        n = 0;
        @(negedge clk);
        while (!axi.bvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_bvalid_seen", axi.bvalid, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_bvalid", i), axi.bvalid, 1);
            chk($sformatf("bp_hold%0d_awready", i), axi.awready, 0);
            @(posedge clk); #1;
        end
        axi.bready = 1;
        @(posedge clk); #1 axi.bready = 0;
        @(negedge clk);
        chk("bp_bvalid_done", axi.bvalid, 0);
        chk("bp_awready_back", axi.awready, 1);
        chk("bp_rw1", rw_regs[63:32], 32'h55);

        // ---- reset during a pending response ----
        @(posedge clk); #1;
        axi.awaddr = 32'h10C; axi.wdata = 32'h77; axi.awvalid = 1; axi.wvalid = 1;
        @(posedge clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
        n = 0;
        @(negedge clk);
        while (!axi.bvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mr_bvalid_seen", axi.bvalid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_bvalid", axi.bvalid, 0);
        chk("mr_awready", axi.awready, 0);
        chk("mr_rw_regs", rw_regs[127:96], 32'h0);
        chk("mr_rw0", rw_regs[31:0], 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
        chk("mr_bvalid_after", axi.bvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
